// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - APB3 requester turning single valid/ready register commands into APB transfers
//
// Purpose:
//   Accepts one register command at a time from a host/sequencer, runs it as
//   an APB3 SETUP + ACCESS transfer toward a slave such as apb_uart_top, and
//   returns exactly one response per command. A wait-state watchdog aborts
//   a transfer whose slave never raises PREADY.
//
// Ports:
//   PCLK, PRESET          clock (rising edge) and synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready is high exactly in IDLE
//   cmd_write/addr/wdata  command fields, latched on acceptance
//   rsp_valid/rsp_ready   response handshake; fields held while stalled
//   rsp_rdata             read data (0 for writes and timeouts)
//   rsp_err               PSLVERR seen in the completing cycle, or timeout
//   rsp_timeout           transfer aborted by the watchdog
//   PSELx/PENABLE/PWRITE/PADDR/PWDATA   APB request outputs (registered)
//   PRDATA/PREADY/PSLVERR               APB completion inputs
//
// Parameters:
//   ADDR_W, DATA_W        address / data widths
//   TIMEOUT_CYCLES        ACCESS cycles allowed before abort; 0 disables it

module apb_cmd_master #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  // The counter must be able to hold TIMEOUT_CYCLES itself, since the abort
  // fires when the count of PREADY-low ACCESS cycles reaches that value.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_n;

  logic              psel_n, penable_n, pwrite_n;
  logic [ADDR_W-1:0] paddr_n;
  logic [DATA_W-1:0] pwdata_n;
  logic              rsp_valid_n, rsp_err_n, rsp_timeout_n;
  logic [DATA_W-1:0] rsp_rdata_n;

  // Only combinational output: the block is free exactly when idle, which
  // also guarantees a single outstanding transfer.
  assign cmd_ready = (state == ST_IDLE);

  always_comb begin
    state_n       = state;
    wait_cnt_n    = wait_cnt;
    psel_n        = PSELx;
    penable_n     = PENABLE;
    pwrite_n      = PWRITE;
    paddr_n       = PADDR;
    pwdata_n      = PWDATA;
    rsp_valid_n   = rsp_valid;
    rsp_rdata_n   = rsp_rdata;
    rsp_err_n     = rsp_err;
    rsp_timeout_n = rsp_timeout;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          // The APB request registers double as the command latch; they stay
          // put until the next accepted command.
          state_n   = ST_SETUP;
          psel_n    = 1'b1;
          penable_n = 1'b0;
          pwrite_n  = cmd_write;
          paddr_n   = cmd_addr;
          pwdata_n  = cmd_wdata;
        end
      end

      ST_SETUP: begin
        // PREADY is deliberately not looked at here.
        state_n    = ST_ACCESS;
        penable_n  = 1'b1;
        wait_cnt_n = CNT_W'(1);
      end

      ST_ACCESS: begin
        if (PREADY) begin
          state_n       = ST_RESP;
          psel_n        = 1'b0;
          penable_n     = 1'b0;
          pwrite_n      = 1'b0;
          rsp_valid_n   = 1'b1;
          rsp_rdata_n   = PWRITE ? '0 : PRDATA;
          rsp_err_n     = PSLVERR;
          rsp_timeout_n = 1'b0;
        end else if (WDOG_EN && (wait_cnt == TMO_VAL)) begin
          state_n       = ST_RESP;
          psel_n        = 1'b0;
          penable_n     = 1'b0;
          pwrite_n      = 1'b0;
          rsp_valid_n   = 1'b1;
          rsp_rdata_n   = '0;
          rsp_err_n     = 1'b1;
          rsp_timeout_n = 1'b1;
        end else if (wait_cnt != {CNT_W{1'b1}}) begin
          // Saturate so a disabled watchdog never wraps back to a small count.
          wait_cnt_n = wait_cnt + CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_n     = ST_IDLE;
          rsp_valid_n = 1'b0;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      PSELx       <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      wait_cnt    <= wait_cnt_n;
      PSELx       <= psel_n;
      PENABLE     <= penable_n;
      PWRITE      <= pwrite_n;
      PADDR       <= paddr_n;
      PWDATA      <= pwdata_n;
      rsp_valid   <= rsp_valid_n;
      rsp_rdata   <= rsp_rdata_n;
      rsp_err     <= rsp_err_n;
      rsp_timeout <= rsp_timeout_n;
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - scoreboard bench for apb_cmd_master with a reactive APB slave model

module tb_apb_cmd_master;

  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int TMO = 16;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          PSELx;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0;
  logic          PSLVERR = 1'b0;

  apb_cmd_master #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // One command plus how the slave will answer it (w = PREADY-low cycles).
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            w;
    logic [DW-1:0] rd;
    logic          er;
  } xfer_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
    int            lat_cyc;
  } exp_t;

  xfer_t cfgq[$];
  exp_t  expq[$];

  int stall   = 0;   // forced rsp_ready-low cycles for the next response
  int rand_rr = 0;   // randomise rsp_ready when nonzero
  int last_hs = 0;   // cycle count at the negedge before the last response handshake

  // ACCESS phase lasts until the slave is ready, capped by the watchdog.
  function automatic int exp_acc(input int w);
    return (w < TMO) ? w + 1 : TMO;
  endfunction

  // Handshake seen at negedge cycle c -> accepted at edge c+1; one SETUP
  // cycle, then exp_acc ACCESS cycles, and rsp_valid is visible afterwards.
  function automatic exp_t model(input xfer_t x, input int c);
    exp_t e;
    e.to      = (x.w >= TMO);
    e.err     = e.to ? 1'b1 : x.er;
    e.rdata   = (e.to || x.wr) ? '0 : x.rd;
    e.lat_cyc = c + 2 + exp_acc(x.w);
    return e;
  endfunction

  // ---------------- APB slave model and protocol monitor ----------------
  initial begin : slave
    xfer_t cur;
    int    acc;
    bit    in_x;
    bit    unstable;
    in_x = 0;
    acc = 0;
    unstable = 0;
    cur = '{wr: 1'b0, addr: '0, wd: '0, w: 0, rd: '0, er: 1'b0};
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        in_x = 0;
        cfgq.delete();
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);
        PRDATA  = DW'($urandom);
      end else begin
        if (rsp_valid)
          chk("one_outstanding", 32'({PSELx, cmd_ready}), 0);
        if (in_x && !PSELx) begin
          chk("access_cycles", acc, exp_acc(cur.w));
          chk("access_stable", 32'(unstable), 0);
          chk("pwrite_idle", 32'(PWRITE), 0);
          chk("penable_idle", 32'(PENABLE), 0);
          in_x = 0;
        end
        if (PSELx && !PENABLE) begin
          chk("setup_expected", 32'(cfgq.size() > 0), 1);
          if (cfgq.size() > 0) begin
            cur = cfgq.pop_front();
            in_x = 1;
            acc = 0;
            unstable = 0;
            chk("setup_addr", 32'(PADDR), 32'(cur.addr));
            chk("setup_wdata", 32'(PWDATA), 32'(cur.wd));
            chk("setup_write", 32'(PWRITE), 32'(cur.wr));
          end
          // Random PREADY during SETUP must not shorten the transfer.
          PREADY  = 1'($urandom);
          PSLVERR = 1'($urandom);
          PRDATA  = DW'($urandom);
        end else if (PSELx && PENABLE && in_x) begin
          acc++;
          if (PADDR !== cur.addr || PWDATA !== cur.wd || PWRITE !== cur.wr)
            unstable = 1;
          if (acc == cur.w + 1) begin
            PREADY  = 1'b1;
            PRDATA  = cur.rd;
            PSLVERR = cur.er;
          end else begin
            PREADY  = 1'b0;
            PRDATA  = DW'($urandom);
            PSLVERR = 1'($urandom);
          end
        end else begin
          PREADY  = 1'($urandom);
          PSLVERR = 1'($urandom);
          PRDATA  = DW'($urandom);
        end
      end
    end
  end

  // ---------------- response monitor / scoreboard ----------------
  initial begin : monitor
    exp_t          e;
    bit            seen;
    bit            bad;
    bit            hs_prev;
    int            first;
    logic [DW-1:0] h_rd;
    logic          h_er;
    logic          h_to;
    seen = 0;
    bad = 0;
    hs_prev = 0;
    first = 0;
    h_rd = '0;
    h_er = 1'b0;
    h_to = 1'b0;
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        seen = 0;
        hs_prev = 0;
        rsp_ready = 1'b0;
      end else begin
        if (hs_prev) chk("rsp_valid_drop", 32'(rsp_valid), 0);
        hs_prev = 0;
        if (rsp_valid) begin
          if (!seen) begin
            seen = 1;
            bad = 0;
            first = cyc;
            h_rd = rsp_rdata;
            h_er = rsp_err;
            h_to = rsp_timeout;
          end else if ({rsp_rdata, rsp_err, rsp_timeout} !== {h_rd, h_er, h_to}) begin
            bad = 1;
          end
          if (stall > 0) begin
            rsp_ready = 1'b0;
            stall--;
          end else begin
            rsp_ready = (rand_rr != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
          end
          if (rsp_ready) begin
            chk("rsp_expected", 32'(expq.size() > 0), 1);
            if (expq.size() > 0) begin
              e = expq.pop_front();
              chk("rsp_rdata", 32'(h_rd), 32'(e.rdata));
              chk("rsp_err", 32'(h_er), 32'(e.err));
              chk("rsp_timeout", 32'(h_to), 32'(e.to));
              chk("rsp_latency", first, e.lat_cyc);
              chk("rsp_stable", 32'(bad), 0);
            end
            last_hs = cyc;
            seen = 0;
            hs_prev = 1;
          end
        end else begin
          seen = 0;
          rsp_ready = (rand_rr != 0) ? 1'($urandom) : 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int w, input logic [DW-1:0] rd, input logic er);
    xfer_t x;
    int    waited;
    bit    ok;
    x = '{wr: wr, addr: a, wd: d, w: w, rd: rd, er: er};
    cfgq.push_back(x);
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    waited = 0;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        ok = 1;
        break;
      end
      waited++;
      @(negedge PCLK);
    end
    chk("cmd_accept_bound", 32'(ok), 1);
    if (ok) begin
      if (waited > 0) chk("accept_after_idle", cyc, last_hs + 1);
      expq.push_back(model(x, cyc));
    end
  endtask

  task automatic idle_cmd();
    @(negedge PCLK);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = DW'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (expq.size() == 0 && !rsp_valid) break;
      @(negedge PCLK);
    end
    chk("drain", expq.size(), 0);
  endtask

  initial begin : main
    int rcnt;
    int r;
    int w;
    int gap;
    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    chk("reset_psel", 32'(PSELx), 0);
    chk("reset_penable", 32'(PENABLE), 0);
    chk("reset_pwrite", 32'(PWRITE), 0);
    chk("reset_paddr", 32'(PADDR), 0);
    chk("reset_pwdata", 32'(PWDATA), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_fields", 32'({rsp_rdata, rsp_err, rsp_timeout}), 0);
    chk("reset_cmd_ready", 32'(cmd_ready), 1);
    PRESET = 1'b0;

    // Directed cases: write, read with 2 waits, slave error then clean,
    // watchdog boundaries (15 waits completes, 16 and more abort).
    issue(1'b1, 4'h1, 8'hA5, 0, 8'h77, 1'b0);
    issue(1'b0, 4'h2, 8'h11, 2, 8'h3C, 1'b0);
    issue(1'b0, 4'hF, 8'h00, 0, 8'h99, 1'b1);
    issue(1'b0, 4'hF, 8'h00, 0, 8'h5B, 1'b0);
    issue(1'b0, 4'h3, 8'h00, 100, 8'hEE, 1'b0);
    issue(1'b0, 4'h4, 8'h00, 15, 8'hC3, 1'b1);
    issue(1'b1, 4'h5, 8'h6D, 16, 8'h00, 1'b0);
    idle_cmd();
    drain();

    // Response stalled 5 cycles while a second command waits.
    stall = 5;
    issue(1'b0, 4'h6, 8'h00, 1, 8'h81, 1'b0);
    issue(1'b1, 4'h7, 8'h42, 0, 8'h00, 1'b0);
    idle_cmd();
    drain();

    // Randomised traffic with random response backpressure.
    rand_rr = 1;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      w = $urandom_range(0, 3);
      else if (r < 8) w = $urandom_range(14, 17);
      else            w = $urandom_range(0, 8);
      issue(1'($urandom), AW'($urandom), DW'($urandom), w, DW'($urandom), 1'($urandom));
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        idle_cmd();
        repeat (gap - 1) @(negedge PCLK);
      end
    end
    idle_cmd();
    drain();
    rand_rr = 0;

    // Reset during an ACCESS wait state: transfer and response are dropped.
    issue(1'b0, 4'h9, 8'h00, 40, 8'hAB, 1'b0);
    idle_cmd();
    for (int i = 0; i < 20; i++) begin
      if (PSELx && PENABLE) break;
      @(negedge PCLK);
    end
    chk("reach_access", 32'(PSELx && PENABLE), 1);
    repeat (2) @(negedge PCLK);
    PRESET = 1'b1;
    expq.delete();
    @(negedge PCLK);
    chk("midreset_psel", 32'(PSELx), 0);
    chk("midreset_penable", 32'(PENABLE), 0);
    chk("midreset_rsp_valid", 32'(rsp_valid), 0);
    @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("midreset_cmd_ready", 32'(cmd_ready), 1);
    rcnt = 0;
    repeat (30) begin
      @(negedge PCLK);
      if (rsp_valid || PSELx) rcnt++;
    end
    chk("no_rsp_after_reset", rcnt, 0);

    // Recovery after reset.
    issue(1'b1, 4'hA, 8'h5A, 1, 8'h00, 1'b0);
    issue(1'b0, 4'hB, 8'h00, 0, 8'hD2, 1'b0);
    idle_cmd();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL global_timeout: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "global timeout");
  end

endmodule
